// File: rtl/credit_valid_sender.sv
// credit_valid_sender: transmit end of a credit/valid link.
// Buffers beats from a local valid/ready source and forwards one beat
// per held credit. The link has no backpressure; credits are the flow control.
module credit_valid_sender #(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_CREDITS  = 16,
  parameter int INIT_CREDITS = 0,
  parameter int BUF_DEPTH    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              in_data,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  input  logic                               credit_in,
  output logic [$clog2(MAX_CREDITS+1)-1:0]   credit_count,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_count,
  output logic                               credit_overflow
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CR_W  = $clog2(MAX_CREDITS+1);
  localparam int CNT_W = $clog2(BUF_DEPTH+1);

  localparam logic [CR_W-1:0]  CR_MAX   = CR_W'(MAX_CREDITS);
  localparam logic [CR_W-1:0]  CR_INIT  = CR_W'(INIT_CREDITS);
  localparam logic [CR_W-1:0]  CR_ONE   = CR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      buf_count_q, buf_count_d;
  logic [CR_W-1:0]       credit_count_q, credit_count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  credit_overflow_q, credit_overflow_d;
  logic                  wr, send;

  // Ready comes only from the registered count, so a full buffer never
  // passes a beat straight through in the same cycle.
  assign in_ready = !rst && (buf_count_q < CNT_FULL);
  assign wr       = in_valid && in_ready;
  assign send     = (buf_count_q != '0) && (credit_count_q != '0);

  // Next-state: buffer write, send decision, occupancy and credit bookkeeping
  always_comb begin
    mem_d             = mem_q;
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    buf_count_d       = buf_count_q;
    credit_count_d    = credit_count_q;
    out_valid_d       = 1'b0;
    out_data_d        = out_data_q;
    credit_overflow_d = credit_overflow_q;

    if (wr) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end

    if (send) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
    end

    case ({wr, send})
      2'b10:   buf_count_d = buf_count_q + CNT_ONE;
      2'b01:   buf_count_d = buf_count_q - CNT_ONE;
      default: buf_count_d = buf_count_q;
    endcase

    // A returned credit that lands on a full counter is lost; flag it sticky.
    if (credit_in && !send) begin
      if (credit_count_q == CR_MAX) credit_overflow_d = 1'b1;
      else                          credit_count_d    = credit_count_q + CR_ONE;
    end else if (!credit_in && send) begin
      credit_count_d = credit_count_q - CR_ONE;
    end
  end

  // Control state; reset flushes the buffer and drops any pending beat
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      buf_count_q       <= '0;
      credit_count_q    <= CR_INIT;
      out_valid_q       <= 1'b0;
      out_data_q        <= '0;
      credit_overflow_q <= 1'b0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      buf_count_q       <= buf_count_d;
      credit_count_q    <= credit_count_d;
      out_valid_q       <= out_valid_d;
      out_data_q        <= out_data_d;
      credit_overflow_q <= credit_overflow_d;
    end
  end

  // Payload storage needs no reset; pointers and count define validity
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign credit_count    = credit_count_q;
  assign buf_count       = buf_count_q;
  assign credit_overflow = credit_overflow_q;

endmodule

// File: tb/tb_credit_valid_sender.sv
// Testbench for credit_valid_sender: queue-based reference model plus
// directed scenarios (reset, credit gating, full buffer, overflow, streaming, flush).
module tb_credit_valid_sender;

  localparam int DW    = 8;
  localparam int MAXC  = 16;
  localparam int INITC = 0;
  localparam int BD    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          credit_in;
  logic [4:0]    credit_count;
  logic [2:0]    buf_count;
  logic          credit_overflow;

  credit_valid_sender #(
    .DATA_WIDTH(DW), .MAX_CREDITS(MAXC), .INIT_CREDITS(INITC), .BUF_DEPTH(BD)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .credit_in(credit_in), .credit_count(credit_count),
    .buf_count(buf_count), .credit_overflow(credit_overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_out = 0;

  logic [DW-1:0] src[$];   // beats the local source still has to offer
  logic [DW-1:0] sb[$];    // scoreboard: accepted beats awaiting transmission
  int            m_cred;
  logic          m_ovf;
  logic [DW-1:0] m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict, clock, compare.
  task automatic tick(input logic cr);
    logic m_ready, wr, send;
    logic [DW-1:0] exp_d;
    in_valid  = (src.size() > 0);
    in_data   = in_valid ? src[0] : '0;
    credit_in = cr;
    #1;
    m_ready = !rst && (sb.size() < BD);
    chk("in_ready", in_ready, m_ready);
    wr   = in_valid && m_ready;
    send = !rst && (sb.size() > 0) && (m_cred > 0);
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_cred = INITC;
      m_ovf  = 1'b0;
      m_last = '0;
      send   = 1'b0;
    end else begin
      if (send) begin
        exp_d  = sb.pop_front();
        m_last = exp_d;
      end
      if (wr) begin
        sb.push_back(in_data);
        void'(src.pop_front());
      end
      if (cr && !send) begin
        if (m_cred == MAXC) m_ovf = 1'b1;
        else                m_cred++;
      end else if (!cr && send) begin
        m_cred--;
      end
    end
    #1;
    chk("out_valid", out_valid, send);
    chk("out_data", out_data, m_last);
    chk("credit_count", credit_count, m_cred);
    chk("buf_count", buf_count, sb.size());
    chk("credit_overflow", credit_overflow, m_ovf);
    if (out_valid) n_out++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; credit_in = 1'b0;
    m_cred = INITC; m_ovf = 1'b0; m_last = '0;

    // Reset state
    tick(1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;

    // 1: beats with no credits stay buffered
    src.push_back(8'hA1); src.push_back(8'hA2); src.push_back(8'hA3);
    n_out = 0;
    repeat (4) tick(1'b0);
    chk("t1_buf_count", buf_count, 3);
    chk("t1_no_out", n_out, 0);
    #1;
    chk("t1_in_ready", in_ready, 1'b1);

    // 2: two credit pulses release A1 then A2
    n_out = 0;
    tick(1'b1); tick(1'b1); tick(1'b0);
    chk("t2_beats", n_out, 2);
    chk("t2_credit", credit_count, 0);
    chk("t2_buf", buf_count, 1);

    // 3: drain A3, then fill beyond depth with no credits, then release
    tick(1'b1); tick(1'b0); tick(1'b0);
    for (int i = 0; i < 5; i++) src.push_back(8'hB0 + 8'(i));
    repeat (8) tick(1'b0);
    chk("t3_full_buf", buf_count, BD);
    #1;
    chk("t3_in_ready_full", in_ready, 1'b0);
    n_out = 0;
    repeat (16) tick(1'b1);
    repeat (3) tick(1'b0);
    chk("t3_beats", n_out, 5);
    chk("t3_credit", credit_count, 11);

    // 4: overflow at ceiling with empty buffer
    repeat (5) tick(1'b1);
    chk("t4_credit_max", credit_count, MAXC);
    chk("t4_no_ovf_yet", credit_overflow, 1'b0);
    tick(1'b1);
    chk("t4_credit_hold", credit_count, MAXC);
    chk("t4_ovf", credit_overflow, 1'b1);
    do_reset();
    chk("t4_ovf_cleared", credit_overflow, 1'b0);
    repeat (16) tick(1'b1);
    src.push_back(8'hC1);
    tick(1'b0);
    n_out = 0;
    tick(1'b1);
    chk("t4_queued_credit", credit_count, MAXC);
    chk("t4_queued_no_ovf", credit_overflow, 1'b0);
    chk("t4_queued_sent", n_out, 1);

    // 5: streaming, credit and data every cycle
    do_reset();
    for (int i = 0; i < 24; i++) src.push_back(8'h10 + 8'(i));
    n_out = 0;
    repeat (20) tick(1'b1);
    chk("t5_beats", n_out, 19);
    chk("t5_credit", credit_count, 1);
    chk("t5_buf", buf_count, 1);
    src.delete();
    repeat (3) tick(1'b0);

    // 6: reset mid-stream flushes three buffered beats
    do_reset();
    src.push_back(8'hD1); src.push_back(8'hD2); src.push_back(8'hD3);
    repeat (4) tick(1'b0);
    chk("t6_pre_buf", buf_count, 3);
    do_reset();
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_buf", buf_count, 0);
    chk("t6_credit", credit_count, INITC);
    src.push_back(8'hE1);
    n_out = 0;
    repeat (4) tick(1'b1);
    chk("t6_only_new", n_out, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
